// File: rtl/gate_pipe.sv
// gate_pipe: pipelined eight-function bitwise gate unit with valid/ready handshake
// and a wrapping count of completed output transfers.
module gate_pipe #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      done_count
);
  logic [WIDTH-1:0] red, res_d;
  logic [WIDTH-1:0] data_q [STAGES];
  logic [STAGES-1:0] vld_q;
  logic [15:0] cnt_q, cnt_d;
  logic adv;
  if (WIDTH < 1 || WIDTH > 64 || STAGES < 1 || STAGES > 4) begin : g_bad
    $error("gate_pipe: WIDTH must be 1..64 and STAGES 1..4");
  end
  always_comb begin
    red = '0;
    red[0] = ~(|a | |b);
  end
  always_comb res_d = op == 3'd0 ? a & b :
                      op == 3'd1 ? a | b :
                      op == 3'd2 ? ~(a | b) :
                      op == 3'd3 ? ~(a & b) :
                      op == 3'd4 ? a ^ b :
                      op == 3'd5 ? ~(a ^ b) :
                      op == 3'd6 ? ~a : red;
  // The whole pipe moves as one; bubbles are shifted, never squeezed out.
  assign adv        = !out_valid || out_ready;
  assign in_ready   = adv && !rst;
  assign out        = data_q[STAGES-1];
  assign out_valid  = vld_q[STAGES-1];
  assign done_count = cnt_q;
  assign cnt_d      = cnt_q + {15'd0, out_valid && out_ready};
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      cnt_q <= '0;
      for (int i = 0; i < STAGES; i++) data_q[i] <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (adv) begin
        data_q[0] <= res_d;
        vld_q[0]  <= in_valid;
        for (int i = 1; i < STAGES; i++) begin
          data_q[i] <= data_q[i-1];
          vld_q[i]  <= vld_q[i-1];
        end
      end
    end
  end
endmodule

// File: tb/tb_gate_pipe.sv
// tb_gate_pipe: directed checks of gate_pipe at 8/2 and at the 1/1 corner.
module tb_gate_pipe;
  logic clk = 0, rst = 1;
  logic iv, ir, ov, ordy;
  logic [7:0] a, b, o;
  logic [2:0] op;
  logic [15:0] dc;
  logic iv1, ir1, ov1, ordy1, a1, b1, o1;
  logic [2:0] op1;
  logic [15:0] dc1;
  int checks = 0, errors = 0;
  logic [7:0] exp_sweep [9] = '{8'hC0, 8'hFC, 8'h03, 8'h3F, 8'h3C, 8'hC3, 8'h0F, 8'h00, 8'h01};
  logic [7:0] bp_a [4] = '{8'h00, 8'h01, 8'h80, 8'hFF};
  logic exp_nor1 [4] = '{1'b1, 1'b0, 1'b0, 1'b0};

  gate_pipe #(.WIDTH(8), .STAGES(2)) u0 (
    .clk(clk), .rst(rst), .in_valid(iv), .in_ready(ir), .a(a), .b(b), .op(op),
    .out(o), .out_valid(ov), .out_ready(ordy), .done_count(dc));
  gate_pipe #(.WIDTH(1), .STAGES(1)) u1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1), .op(op1),
    .out(o1), .out_valid(ov1), .out_ready(ordy1), .done_count(dc1));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1;
    tick();
    rst = 0;
    #1;
  endtask

  initial begin
    iv = 0; ordy = 1; a = 0; b = 0; op = 0;
    iv1 = 0; ordy1 = 1; a1 = 0; b1 = 0; op1 = 3'd2;
    #1;
    chk("rst_out", o, 0);
    chk("rst_ovalid", ov, 0);
    chk("rst_iready", ir, 0);
    chk("rst_count", dc, 0);
    rst = 0;
    #1;
    chk("post_rst_iready", ir, 1);

    for (int i = 0; i < 11; i++) begin
      iv = i < 9;
      a = i == 8 ? 8'h00 : 8'hF0;
      b = i == 8 ? 8'h00 : 8'hCC;
      op = i == 8 ? 3'd7 : 3'(i);
      tick();
      if (i >= 1 && i <= 9) begin
        chk("sweep_valid", ov, 1);
        chk("sweep_out", o, exp_sweep[i-1]);
      end
    end
    chk("sweep_drained", ov, 0);
    chk("sweep_count", dc, 9);

    do_reset();
    op = 3'd2; b = 8'h00; iv = 1; ordy = 1;
    a = bp_a[0]; tick();
    chk("bp_not_yet", ov, 0);
    a = bp_a[1]; tick();
    chk("bp_first", o, 8'hFF);
    a = bp_a[2]; ordy = 0; #1;
    chk("bp_stall_iready", ir, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_stall_out", o, 8'hFF);
      chk("bp_stall_valid", ov, 1);
      chk("bp_stall_count", dc, 0);
    end
    ordy = 1; #1;
    chk("bp_release_iready", ir, 1);
    tick();
    chk("bp_second", o, 8'hFE);
    a = bp_a[3]; tick();
    chk("bp_third", o, 8'h7F);
    iv = 0; tick();
    chk("bp_fourth", o, 8'h00);
    chk("bp_fourth_valid", ov, 1);
    tick();
    chk("bp_end_valid", ov, 0);
    chk("bp_count", dc, 4);

    do_reset();
    op = 3'd4; b = 8'h55;
    for (int k = 1; k <= 10; k++) begin
      iv = 1; a = 8'(k - 1);
      tick();
      chk("thr_valid", ov, k >= 2);
      if (k >= 2) chk("thr_out", o, 8'(k - 2) ^ 8'h55);
    end
    iv = 0;
    tick();
    chk("thr_last", o, 8'h09 ^ 8'h55);
    tick();
    chk("thr_count", dc, 10);

    do_reset();
    ordy = 0; iv = 1; op = 3'd0; a = 8'hAA; b = 8'hFF;
    tick();
    a = 8'h55; tick();
    chk("mid_valid_before", ov, 1);
    iv = 0; rst = 1; #1;
    chk("mid_rst_valid", ov, 0);
    chk("mid_rst_out", o, 0);
    chk("mid_rst_count", dc, 0);
    chk("mid_rst_iready", ir, 0);
    tick();
    rst = 0; ordy = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mid_no_stale", ov, 0);
    end

    for (int i = 0; i < 4; i++) begin
      iv1 = 1; a1 = i[1]; b1 = i[0];
      tick();
      chk("w1_valid", ov1, 1);
      chk("w1_nor", o1, exp_nor1[i]);
    end
    iv1 = 0; tick();
    chk("w1_drained", ov1, 0);
    chk("w1_count", dc1, 4);

    do_reset();
    iv = 1; ordy = 1; op = 3'd1; a = 8'h12; b = 8'h34;
    repeat (65537) tick();
    chk("wrap_ffff", dc, 16'hFFFF);
    tick();
    chk("wrap_zero", dc, 16'h0000);
    iv = 0;
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/gate_pipe.md
# gate_pipe

Parametrised, pipelined bitwise gate unit with valid/ready handshake. Takes two WIDTH-bit operands and an op code, and evaluates one of eight gate functions: AND, OR, NOR, NAND, XOR, XNOR, NOT, or reduction-NOR. The result is carried through STAGES registered stages, with backpressure. It replaces the single-function, single-bit combinational gates in the Gates library wherever a gate sits on a registered datapath between handshaking producers and consumers.

## Interface
Parameters:
- WIDTH, 8, operand/result width in bits; legal range 1..64.
- STAGES, 2, pipeline depth in register stages; legal range 1..4. An out-of-range value is an elaboration error.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  operand set a/b/op is valid.
- in_ready  output  1  block accepts the operand set this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- op  input  3  function select, sampled together with a/b.
- out  output  WIDTH  result of the oldest transaction in flight.
- out_valid  output  1  out holds a valid result.
- out_ready  input  1  consumer accepts out this cycle.
- done_count  output  16  number of output handshakes completed; wraps modulo 2^16.

## Operation
- Op encoding, bitwise over WIDTH:
  - 0: a&b
  - 1: a|b
  - 2: ~(a|b)
  - 3: ~(a&b)
  - 4: a^b
  - 5: ~(a^b)
  - 6: ~a (b ignored)
  - 7: reduction-NOR. out[0] = ~(|a | |b); out[WIDTH-1:1] = 0.
- Input handshake: a transfer occurs in a cycle where in_valid && in_ready.
- Output handshake: a transfer occurs in a cycle where out_valid && out_ready.
- Function evaluation is combinational from a/b/op. The result is captured into stage 1 on the accepting edge. Stages 2..STAGES are pure shift registers, each holding data plus a valid bit. The last stage drives out and out_valid.
- Global advance: adv = !out_valid || out_ready.
  - When adv=1, every stage loads from its predecessor.
  - Stage 1 loads the new result with valid = in_valid.
  - When adv=0, all stages hold.
- in_ready = adv && !rst. This is a combinational path from out_ready and out_valid.
- A bubble, i.e. a stage with valid=0, is shifted like data. Bubbles are not collapsed while the output is stalled.
- done_count increments by 1 on each output handshake. 0xFFFF + 1 = 0x0000.
- With in_valid=0, a and b are don't-care. Stage 1 valid clears on the next advancing edge.
- Reset asserted at any time, including mid-transfer or mid-stall:
  - All stage valids and data go to 0 immediately.
  - In-flight transactions are discarded.
  - Outputs: out=0, out_valid=0, done_count=0, in_ready=0.
- After rst deasserts, in_ready=1 in the first cycle.

## Timing
- Latency: an operand set accepted in cycle c appears with out_valid=1 in cycle c+STAGES, provided no stall occurs in between.
- Throughput: one transaction per cycle while out_ready=1.
- Stall: if out_valid=1 and out_ready=0, in_ready=0 in the same cycle. Input and all stages hold. out must stay stable until the handshake.
- Simultaneous output handshake and input handshake in one cycle: both complete, with no lost or duplicated result.
- Ordering: results leave in acceptance order.
- Capacity: at most STAGES transactions are in flight.
- No combinational path from a, b or op to out. Only the in_ready path from out_ready is combinational.

## Test plan
All scenarios use WIDTH=8, STAGES=2 unless stated.
- Reset values: with rst=1, check out=0x00, out_valid=0, in_ready=0, done_count=0. Release rst, then check in_ready=1.
- Op sweep: set a=0xF0, b=0xCC with out_ready=1 and apply op 0..7 back-to-back. Expect, each in cycle c+2:
  - 0xC0, 0xFC, 0x03, 0x3F, 0x3C, 0xC3, 0x0F, 0x00.
  - Then op=7 with a=0, b=0 gives 0x01.
- Backpressure: stream 4 transactions with op=2, a=0x00/0x01/0x80/0xFF, b=0x00, while out_ready=0 for 3 cycles mid-stream.
  - Expect 0xFF, 0xFE, 0x7F, 0x00 in order, none lost or duplicated.
  - out is stable during the stall, and done_count=4 at the end.
- Full throughput: with in_valid=1 and out_ready=1 for 10 cycles, expect out_valid=1 every cycle from cycle 2 onward and done_count=10.
- Reset mid-flight: accept 2 transactions, assert rst for 1 cycle while out_ready=0.
  - Expect out_valid=0 immediately and done_count=0.
  - No stale result emerges after release.
- Parameter corners and wrap:
  - WIDTH=1, STAGES=1: exhaustive a/b over op 2 gives 1, 0, 0, 0, with latency 1.
  - Preload done_count near wrap by running 65536 handshakes: check it returns to 0x0000.
